// File: rtl/reg_file_param.sv
// reg_file_param: 2R1W register file with a post-reset clear sweep, zero register, write bypass; ports clk, reset, wr_en/wr_addr/wr_data, rd_addr1/2 -> rd_data1/2, ready, wr_err
module reg_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              ready,
  output logic              wr_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0, IDLE = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  assign ready = state == IDLE;
  always_comb begin
    we = !reset && (state == CLEAR || (wr_en && !(ZERO_REG && wr_addr == '0)));
    wa = state == CLEAR ? cnt : wr_addr;
    wd = state == CLEAR ? RESET_VAL : wr_data;
  end
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      cnt    <= '0;
      wr_err <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= IDLE;
      if (wr_en) wr_err <= 1'b1;
    end
  end
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return state == CLEAR ? '0 :
           (ZERO_REG && a == '0) ? '0 :
           (BYPASS && wr_en && wr_addr == a) ? wr_data : mem[a];
  endfunction
  assign rd_data1 = rd(rd_addr1);
  assign rd_data2 = rd(rd_addr2);
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed checks of clear sweep, bypass, zero register, sticky error and narrow config
module tb_reg_file_param;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0;
  logic [4:0] wr_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic a_rdy, a_err, b_rdy, b_err;
  logic w2_en = 1'b0;
  logic [2:0] w2_addr = '0, r2_addr1 = '0, r2_addr2 = '0;
  logic [15:0] w2_data = '0, c_d1, c_d2;
  logic c_rdy, c_err;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  reg_file_param u_a (.clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_d1), .rd_data2(a_d2), .ready(a_rdy), .wr_err(a_err));
  reg_file_param #(.RESET_VAL(32'h0000_00C3), .BYPASS(1'b0)) u_b (.clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_d1),
    .rd_data2(b_d2), .ready(b_rdy), .wr_err(b_err));
  reg_file_param #(.DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h1111)) u_c (.clk(clk), .reset(reset), .wr_en(w2_en),
    .wr_addr(w2_addr), .wr_data(w2_data), .rd_addr1(r2_addr1), .rd_addr2(r2_addr2), .rd_data1(c_d1),
    .rd_data2(c_d2), .ready(c_rdy), .wr_err(c_err));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rd_addr1 = 5'd5;
    tick; tick;
    check("rst_ready", {31'd0, a_rdy}, 0);
    check("rst_err", {31'd0, a_err}, 0);
    check("rst_rd1", a_d1, 0);
    check("rst_rd1_b", b_d1, 0);
    check("rst_ready_c", {31'd0, c_rdy}, 0);
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick;
      check($sformatf("clr_ready_a_%0d", i), {31'd0, a_rdy}, {31'd0, i == 32});
      check($sformatf("clr_ready_b_%0d", i), {31'd0, b_rdy}, {31'd0, i == 32});
      if (i <= 8) check($sformatf("clr_ready_c_%0d", i), {31'd0, c_rdy}, {31'd0, i == 8});
      if (i == 5) check("clr_rd_zero_b", b_d1, 0);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #1;
      check($sformatf("init_a_%0d", a), a_d1, 0);
      check($sformatf("init_b_%0d", a), b_d1, a == 0 ? 32'd0 : 32'hC3);
      check($sformatf("init_b2_%0d", a), b_d2, a == 31 ? 32'd0 : 32'hC3);
    end
    for (int a = 0; a < 8; a++) begin
      r2_addr1 = 3'(a);
      #1;
      check($sformatf("init_c_%0d", a), {16'd0, c_d1}, a == 0 ? 32'd0 : 32'h1111);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd7;
    #1;
    check("byp_a", a_d1, 32'hDEADBEEF);
    check("nobyp_b", b_d1, 32'hC3);
    tick;
    wr_en = 1'b0;
    #1;
    check("wr7_a", a_d1, 32'hDEADBEEF);
    check("wr7_b", b_d1, 32'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    check("zero_byp_rd1", a_d1, 0);
    check("zero_byp_rd2", a_d2, 0);
    tick;
    wr_en = 1'b0;
    #1;
    check("zero_rd1", a_d1, 0);
    check("zero_rd2", a_d2, 0);
    check("zero_err", {31'd0, a_err}, 0);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAAAA5555;
    tick;
    wr_addr = 5'd1; wr_data = 32'h0F0F1234;
    tick;
    wr_en = 1'b0; rd_addr1 = 5'd31; rd_addr2 = 5'd1;
    #1;
    check("dual_31", a_d1, 32'hAAAA5555);
    check("dual_1", a_d2, 32'h0F0F1234);
    rd_addr1 = 5'd1; rd_addr2 = 5'd31;
    #1;
    check("swap_1", a_d1, 32'h0F0F1234);
    check("swap_31", a_d2, 32'hAAAA5555);
    rd_addr1 = 5'd31;
    #1;
    check("same_addr", a_d1, a_d2);
    check("same_addr_b", b_d1, 32'hAAAA5555);
    w2_en = 1'b1; w2_addr = 3'd7; w2_data = 16'hBEEF;
    tick;
    w2_addr = 3'd1; w2_data = 16'h1234;
    tick;
    w2_en = 1'b0; r2_addr1 = 3'd7; r2_addr2 = 3'd1;
    #1;
    check("c_dual_7", {16'd0, c_d1}, 32'hBEEF);
    check("c_dual_1", {16'd0, c_d2}, 32'h1234);
    check("c_err", {31'd0, c_err}, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF0000; end
      tick;
      wr_en = 1'b0;
      if (i == 9) check("err_before", {31'd0, a_err}, 0);
      if (i == 10) check("err_set", {31'd0, a_err}, 1);
      if (i >= 31) check($sformatf("clr2_ready_%0d", i), {31'd0, a_rdy}, {31'd0, i == 32});
    end
    rd_addr1 = 5'd3; rd_addr2 = 5'd7;
    #1;
    check("ent3_a", a_d1, 0);
    check("ent3_b", b_d1, 32'hC3);
    check("ent7_recleared", a_d2, 0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h1;
    tick;
    wr_en = 1'b0;
    #1;
    check("err_sticky", {31'd0, a_err}, 1);
    check("err_sticky_b", {31'd0, b_err}, 1);
    reset = 1'b1;
    tick;
    check("err_cleared", {31'd0, a_err}, 0);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) tick;
    check("mid_ready", {31'd0, a_rdy}, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick;
      if (i >= 12) check($sformatf("restart_ready_%0d", i), {31'd0, a_rdy}, {31'd0, i == 32});
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
